alu_issue: RTL and testbench
============================

# alu_issue

Sequencing stage that feeds the 16-bit combinational ALU and retires its results. It accepts one command at a time over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU operand/mode/carry inputs from registers, then captures Y/Cout/Overflow into the destination register and a result port. It owns both the ALU's upstream operand path and its downstream write-back.

## Interface
- `N`, 16: data width; must match ALU operand width.
- `RA`, 2: register-file address width; 2^RA registers of N bits.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept; high only in IDLE and not in reset.
- `cmd_load`  in  1  1 = load `cmd_imm` into `cmd_dst`; 0 = ALU op.
- `cmd_mode`  in  4  ALU mode code 0–15; ignored when `cmd_load`=1.
- `cmd_cin`  in  1  carry-in request (see Configuration).
- `cmd_sa`, `cmd_sb`  in  RA  source register indices for A and B.
- `cmd_dst`  in  RA  destination register index.
- `cmd_imm`  in  N  immediate for load.
- `alu_a`, `alu_b`  out  N  registered ALU operands.
- `alu_mode`  out  4  registered ALU mode.
- `alu_cin`  out  1  registered ALU carry-in.
- `alu_y`  in  N  ALU result, combinational from `alu_*`.
- `alu_cout`, `alu_overflow`  in  1  ALU flags.
- `res_valid`  out  1  one-cycle pulse: result retired.
- `res_y`  out  N  retired result; held until next retire.
- `res_cout`, `res_overflow`  out  1  retired flags; held.

## Operation
- FSM states: IDLE, EXEC.
  - IDLE→EXEC on accept (`cmd_valid && cmd_ready`).
  - EXEC→IDLE unconditionally after one cycle.
- On accept of an ALU op, registered in the same edge:
  - `alu_a`←reg[`cmd_sa`], `alu_b`←reg[`cmd_sb`].
  - `alu_mode`←`cmd_mode`, `alu_cin`←carry select.
  - `dst` is latched.
- On accept of a load:
  - `alu_a`←0, `alu_b`←`cmd_imm`, `alu_mode`←4'd14 (pass B), `alu_cin`←0.
  - The load retires through the ALU like any op.
- Retire happens at the EXEC→IDLE edge:
  - reg[dst]←`alu_y`.
  - `res_y`/`res_cout`/`res_overflow`←`alu_y`/`alu_cout`/`alu_overflow`.
  - `res_valid`←1, deasserted on the following edge.
- `sa`, `sb` and `dst` may alias; operands are read before the write-back.
- `alu_*` outputs hold their last values in IDLE.
- `cmd_*` inputs are ignored outside the accept cycle. The block never accepts in EXEC, even with `cmd_valid` held high.
- Reset values:
  - All registers 0.
  - `alu_a`/`alu_b` 0, `alu_mode` 0, `alu_cin` 0.
  - `res_*` 0, `res_valid` 0.
  - State IDLE.
- Reset asserted in EXEC aborts the op: no register write, no `res_valid` pulse.

## Timing
- Accept on edge t → `alu_*` valid in cycle t+1 (EXEC) → retire on edge t+2; `res_valid` is high during cycle t+2.
- `cmd_ready` is low in cycle t+1 and high again in cycle t+2.
- Maximum throughput is one command per 2 cycles.
- A command accepted at edge t+3 reads the value written at t+2. There is no hazard and no bypass is needed.
- `cmd_ready` = (state==IDLE) & ~`rst`. It does not depend on `cmd_valid`.

## Configuration
- `ALU_ISSUE_CARRY_CHAIN_EN` defined:
  - A carry-flag register is added; it resets to 0.
  - It is updated with `alu_cout` on every non-load retire.
  - `alu_cin`←(`cmd_cin` ? carry_flag : 0), which supports multi-word add/sub.
- Not defined:
  - `alu_cin`←`cmd_cin` directly.
  - No carry-flag register exists.

## Test plan
- Reset: hold `rst` 2 cycles → all `res_*`=0, `cmd_ready`=0 during reset and 1 the cycle after; reads of r0–r3 via mode 14 return 0.
- Load + add: load r0=0x0003, r1=0x0004, then mode 4 r2=r0+r1, cin=0 → `res_y`=0x0007, `res_valid` exactly one cycle, 2 cycles after accept.
- Overflow: r0=0x7FFF, r1=0x0001, mode 4 → `res_y`=0x8000, `res_overflow`=1, `res_cout`=0.
- Backpressure: `cmd_valid` held high 6 cycles with the same command → exactly 3 accepts, 3 `res_valid` pulses, `cmd_ready` alternating 1/0.
- Reset mid-op: accept mode 4 writing r3, assert `rst` in EXEC → no `res_valid`, r3 reads 0 afterwards.
- Carry chain (macro on): 0xFFFF+0x0001 → `res_y`=0x0000, `res_cout`=1; then 0x0000+0x0000 with `cmd_cin`=1 → `res_y`=0x0001. Macro off, same sequence → 0x0001 only because `cmd_cin`=1 directly; with `cmd_cin`=0 → 0x0000.

Source files
------------

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - command sequencer feeding a 16-bit combinational ALU and retiring its results
// Optional feature macro: ALU_ISSUE_CARRY_CHAIN_EN (carry-flag register for multi-word add/sub)
module alu_issue #(
    parameter int N  = 16,
    parameter int RA = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [3:0]    cmd_mode,
    input  logic          cmd_cin,
    input  logic [RA-1:0] cmd_sa,
    input  logic [RA-1:0] cmd_sb,
    input  logic [RA-1:0] cmd_dst,
    input  logic [N-1:0]  cmd_imm,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_mode,
    output logic          alu_cin,
    input  logic [N-1:0]  alu_y,
    input  logic          alu_cout,
    input  logic          alu_overflow,
    output logic          res_valid,
    output logic [N-1:0]  res_y,
    output logic          res_cout,
    output logic          res_overflow
);

    localparam int NREG = 2 ** RA;
    localparam logic [3:0] MODE_PASS_B = 4'd14;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          retire;
    logic          cin_sel;
    logic [RA-1:0] dst;
    logic [N-1:0]  regs [NREG];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: one EXEC cycle per accepted command
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and retire strobes; reset masks both so an op in flight is dropped
    always_comb begin
        cmd_ready = (state == IDLE) && !rst;
        accept    = cmd_valid && cmd_ready;
        retire    = (state == EXEC) && !rst;
    end

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    logic carry_flag;
    logic exec_load;

    assign cin_sel = cmd_cin ? carry_flag : 1'b0;

    // Carry flag tracks the carry-out of the last retired ALU op; loads leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_flag <= 1'b0;
            exec_load  <= 1'b0;
        end else begin
            if (accept) exec_load <= cmd_load;
            if (retire && !exec_load) carry_flag <= alu_cout;
        end
    end
`else
    assign cin_sel = cmd_cin;
`endif

    // Operand/mode registers driving the ALU, captured on accept and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= 4'd0;
            alu_cin  <= 1'b0;
            dst      <= '0;
        end else if (accept) begin
            dst <= cmd_dst;
            if (cmd_load) begin
                alu_a    <= '0;
                alu_b    <= cmd_imm;
                alu_mode <= MODE_PASS_B;
                alu_cin  <= 1'b0;
            end else begin
                alu_a    <= regs[cmd_sa];
                alu_b    <= regs[cmd_sb];
                alu_mode <= cmd_mode;
                alu_cin  <= cin_sel;
            end
        end
    end

    // Register file write-back at retire
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (retire) begin
            regs[dst] <= alu_y;
        end
    end

    // Result port: single-cycle valid pulse, data and flags held until the next retire
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_y        <= '0;
            res_cout     <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            res_valid <= retire;
            if (retire) begin
                res_y        <= alu_y;
                res_cout     <= alu_cout;
                res_overflow <= alu_overflow;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue with a behavioural ALU and register-file model
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_load = 1'b0;
    logic [3:0]  cmd_mode = 4'd0;
    logic        cmd_cin = 1'b0;
    logic [1:0]  cmd_sa = 2'd0;
    logic [1:0]  cmd_sb = 2'd0;
    logic [1:0]  cmd_dst = 2'd0;
    logic [15:0] cmd_imm = 16'd0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_mode;
    logic        alu_cin;
    logic [15:0] alu_y;
    logic        alu_cout, alu_overflow;
    logic        res_valid;
    logic [15:0] res_y;
    logic        res_cout, res_overflow;

    int errors = 0;
    int checks = 0;

    logic [15:0] mdl [4];
    logic        mdl_cf;

    always #5 clk = ~clk;

    alu_issue #(.N(16), .RA(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_mode(cmd_mode), .cmd_cin(cmd_cin),
        .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_y(res_y), .res_cout(res_cout), .res_overflow(res_overflow)
    );

    // Reference ALU: returns {overflow, cout, y}
    function automatic logic [17:0] ref_alu(input logic [3:0] m, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic [15:0] bb;
        case (m)
            4'd0:  return {2'b00, a & b};
            4'd1:  return {2'b00, a | b};
            4'd2:  return {2'b00, a ^ b};
            4'd4, 4'd5: begin
                bb = (m == 4'd5) ? ~b : b;
                s  = {1'b0, a} + {1'b0, bb} + {16'd0, c};
                return {(a[15] == bb[15]) && (s[15] != a[15]), s[16], s[15:0]};
            end
            4'd14: return {2'b00, b};
            default: return {2'b00, a};
        endcase
    endfunction

    always_comb {alu_overflow, alu_cout, alu_y} = ref_alu(alu_mode, alu_a, alu_b, alu_cin);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl[i] = 16'd0;
        mdl_cf = 1'b0;
    endtask

    // One command from IDLE: checks operands in EXEC and the retired result
    task automatic issue(input logic ld, input logic [3:0] md, input logic ci,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] dst, input logic [15:0] imm);
        logic [15:0] ea, eb;
        logic [3:0]  em;
        logic        ec;
        logic [17:0] r;
        if (ld) begin
            ea = 16'd0; eb = imm; em = 4'd14; ec = 1'b0;
        end else begin
            ea = mdl[sa]; eb = mdl[sb]; em = md;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
            ec = ci ? mdl_cf : 1'b0;
`else
            ec = ci;
`endif
        end
        r = ref_alu(em, ea, eb, ec);
        chk("ready_idle", cmd_ready, 1);
        cmd_load = ld; cmd_mode = md; cmd_cin = ci;
        cmd_sa = sa; cmd_sb = sb; cmd_dst = dst; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_load = $urandom_range(0, 1); cmd_sa = 2'($urandom); cmd_imm = 16'($urandom);
        chk("ready_exec", cmd_ready, 0);
        chk("res_valid_exec", res_valid, 0);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_mode", alu_mode, em);
        chk("alu_cin", alu_cin, ec);
        @(posedge clk); #1;
        chk("res_valid", res_valid, 1);
        chk("res_y", res_y, r[15:0]);
        chk("res_cout", res_cout, r[16]);
        chk("res_overflow", res_overflow, r[17]);
        chk("ready_retire", cmd_ready, 1);
        mdl[dst] = r[15:0];
        if (!ld) mdl_cf = r[16];
    endtask

    initial begin
        int acc;
        int pulses;
        logic [17:0] bp;
        model_reset();

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_y", res_y, 0);
        chk("rst_res_flags", {res_cout, res_overflow}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_mode", alu_mode, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) issue(1'b0, 4'd14, 1'b0, 2'(i), 2'(i), 2'(i), 16'd0);

        // Load and add
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0003);
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0004);
        issue(1'b0, 4'd4, 1'b0, 2'd0, 2'd1, 2'd2, 16'd0);
        chk("add_value", res_y, 16'h0007);

        // Signed overflow
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h7FFF);
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0001);
        issue(1'b0, 4'd4, 1'b0, 2'd0, 2'd1, 2'd2, 16'd0);
        chk("ovf_value", {res_overflow, res_cout, res_y}, {2'b10, 16'h8000});

        // Backpressure: valid held six cycles with the same command
        cmd_load = 1'b0; cmd_mode = 4'd4; cmd_cin = 1'b0;
        cmd_sa = 2'd0; cmd_sb = 2'd1; cmd_dst = 2'd2;
        cmd_valid = 1'b1;
        acc = 0; pulses = 0;
        bp = ref_alu(4'd4, mdl[0], mdl[1], 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_ready", cmd_ready, (i % 2 == 0) ? 1 : 0);
            if (cmd_ready) acc++;
            @(posedge clk); #1;
            if (res_valid) begin
                pulses++;
                chk("bp_res_y", res_y, bp[15:0]);
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepts", acc, 3);
        chk("bp_pulses", pulses, 3);
        mdl[2] = bp[15:0];
        mdl_cf = bp[16];

        // Randomised commands, aliasing allowed
        for (int n = 0; n < 30; n++) begin
            issue(1'($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
        end

        // Reset while in EXEC aborts the op
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h1234);
        cmd_load = 1'b0; cmd_mode = 4'd4; cmd_cin = 1'b0;
        cmd_sa = 2'd0; cmd_sb = 2'd0; cmd_dst = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_y", res_y, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("abort_res_valid_after", res_valid, 0);
        issue(1'b0, 4'd14, 1'b0, 2'd0, 2'd3, 2'd3, 16'd0);
        chk("abort_r3", res_y, 0);
        issue(1'b0, 4'd14, 1'b0, 2'd0, 2'd0, 2'd0, 16'd0);
        chk("abort_r0", res_y, 0);

        // Carry chain sequence
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0001);
        issue(1'b0, 4'd4, 1'b0, 2'd0, 2'd1, 2'd2, 16'd0);
        chk("carry_lo", {res_cout, res_y}, {1'b1, 16'h0000});
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
        issue(1'b1, 4'd0, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0000);
        issue(1'b0, 4'd4, 1'b1, 2'd0, 2'd1, 2'd3, 16'd0);
        chk("carry_hi", res_y, 16'h0001);
        issue(1'b0, 4'd4, 1'b0, 2'd0, 2'd1, 2'd3, 16'd0);
        chk("carry_off", res_y, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
